// File: rtl/bus_pkg.sv
// Shared types for the data-side bus: transfer size, transfer type and the
// dbus_master sequencing states.
package bus_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RMW_ISSUE_RD,
    RMW_WAIT_RD,
    RESP
  } dbus_master_state_e;

  // Right-aligned store data copied into every lane of the bus word.
  function automatic logic [31:0] lane_replicate(input logic [31:0] d, input tsize_e sz);
    case (sz)
      BYTE:     return {4{d[7:0]}};
      HALFWORD: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Shared slave bus as seen by one initiator: bstart/bdone handshake plus
// address, data, size and direction.
interface master_bus_if;
  import bus_pkg::*;

  logic        bstart;
  ttype_e      ttype;
  tsize_e      tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bdone;
  logic [31:0] rdata;

  modport master (
    output bstart, ttype, tsize, addr, wdata,
    input  bdone, rdata
  );

  modport slave (
    input  bstart, ttype, tsize, addr, wdata,
    output bdone, rdata
  );

endinterface

// File: rtl/dbus_lane_unit.sv
// Combinational lane handling: misalignment check, load sign/zero extension
// and, with DBUS_MASTER_RMW_EN, merging sub-word store data into a read word.
module dbus_lane_unit
  import bus_pkg::*;
(
  input  logic [1:0]  chk_addr_i,
  input  tsize_e      chk_size_i,
  output logic        misaligned_o,
  input  tsize_e      ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
`ifdef DBUS_MASTER_RMW_EN
  ,
  input  logic [1:0]  mg_addr_i,
  input  tsize_e      mg_size_i,
  input  logic [15:0] mg_wdata_i,
  input  logic [31:0] mg_rdata_i,
  output logic [31:0] mg_word_o
`endif
);

  assign misaligned_o = ((chk_size_i == WORD) && (chk_addr_i != 2'b00)) ||
                        ((chk_size_i == HALFWORD) && chk_addr_i[0]);

  // Slaves return the lane already right-aligned; only the upper bits change.
  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      BYTE:     ld_data_o = {{24{~ld_unsigned_i & ld_rdata_i[7]}}, ld_rdata_i[7:0]};
      HALFWORD: ld_data_o = {{16{~ld_unsigned_i & ld_rdata_i[15]}}, ld_rdata_i[15:0]};
      default:  ;
    endcase
  end

`ifdef DBUS_MASTER_RMW_EN
  always_comb begin
    mg_word_o = mg_rdata_i;
    case (mg_size_i)
      BYTE:     mg_word_o[{mg_addr_i, 3'b000} +: 8]     = mg_wdata_i[7:0];
      HALFWORD: mg_word_o[{mg_addr_i[1], 4'b0000} +: 16] = mg_wdata_i;
      default:  ;
    endcase
  end
`endif

endmodule

// File: rtl/dbus_master.sv
// Data-side bus initiator: one CPU load/store becomes one or two bus cycles.
// Define DBUS_MASTER_RMW_EN to make sub-word stores read-modify-write.
module dbus_master
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  tsize_e             req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  master_bus_if.master       bus
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES);

  dbus_master_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  tsize_e        size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  tsize_e        bus_tsize_q, bus_tsize_d;
  ttype_e        bus_ttype_q, bus_ttype_d;
`ifdef DBUS_MASTER_RMW_EN
  logic [1:0]    lane_q, lane_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [31:0]   merged;
`endif

  logic        misaligned;
  logic [31:0] ld_data;
  logic        timeout_hit;

  dbus_lane_unit u_lane (
    .chk_addr_i    (req_addr[1:0]),
    .chk_size_i    (req_size),
    .misaligned_o  (misaligned),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (bus.rdata),
    .ld_data_o     (ld_data)
`ifdef DBUS_MASTER_RMW_EN
    ,
    .mg_addr_i     (lane_q),
    .mg_size_i     (size_q),
    .mg_wdata_i    (wdata_q),
    .mg_rdata_i    (bus.rdata),
    .mg_word_o     (merged)
`endif
  );

  // Down-counter loaded at issue; terminal count 1 means the budget is spent.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_tsize_d = bus_tsize_q;
    bus_ttype_d = bus_ttype_q;
`ifdef DBUS_MASTER_RMW_EN
    lane_d      = lane_q;
    wdata_d     = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          we_d    = req_we;
          rdata_d = '0;
          err_d   = 1'b0;
`ifdef DBUS_MASTER_RMW_EN
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
`endif
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`ifdef DBUS_MASTER_RMW_EN
          else if (req_we && (req_size != WORD)) begin
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_ttype_d = READ;
            bus_tsize_d = WORD;
            bus_wdata_d = '0;
            state_d     = RMW_ISSUE_RD;
          end
`endif
          else begin
            bus_addr_d  = req_addr;
            bus_ttype_d = req_we ? WRITE : READ;
            bus_tsize_d = req_size;
            bus_wdata_d = lane_replicate(req_wdata, req_size);
            state_d     = ISSUE;
          end
        end
      end
      ISSUE, WAIT: begin
        if (bus.bdone) begin
          rdata_d = we_q ? '0 : ld_data;
          state_d = RESP;
        end else if (state_q == ISSUE) begin
          cnt_d   = TO_LOAD;
          state_d = WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef DBUS_MASTER_RMW_EN
      RMW_ISSUE_RD, RMW_WAIT_RD: begin
        if (bus.bdone) begin
          bus_wdata_d = merged;
          bus_ttype_d = WRITE;
          bus_tsize_d = WORD;
          state_d     = ISSUE;
        end else if (state_q == RMW_ISSUE_RD) begin
          cnt_d   = TO_LOAD;
          state_d = RMW_WAIT_RD;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= WORD;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_tsize_q <= WORD;
      bus_ttype_q <= READ;
`ifdef DBUS_MASTER_RMW_EN
      lane_q      <= '0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_tsize_q <= bus_tsize_d;
      bus_ttype_q <= bus_ttype_d;
`ifdef DBUS_MASTER_RMW_EN
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  assign bus.bstart = (state_q == ISSUE) || (state_q == RMW_ISSUE_RD);
  assign bus.addr   = bus_addr_q;
  assign bus.wdata  = bus_wdata_q;
  assign bus.tsize  = bus_tsize_q;
  assign bus.ttype  = bus_ttype_q;

endmodule

// File: tb/tb_dbus_master.sv
// Directed bench for dbus_master with a one-cycle slave model; expectations
// follow DBUS_MASTER_RMW_EN when it is defined for the build.
module tb_dbus_master;
  import bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  tsize_e      req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  master_bus_if bus_if();

  logic        slv_bdone;
  logic [31:0] slv_rdata;
  logic        inj_bdone;
  logic        slv_mute;
  logic [31:0] slv_rd_val;
  int          n_bstart;
  int          checks;
  int          errors;

  assign bus_if.bdone = slv_bdone | inj_bdone;
  assign bus_if.rdata = slv_rdata;

  dbus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus          (bus_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle slave: answers the cycle after bstart unless muted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_bdone <= 1'b0;
      slv_rdata <= '0;
    end else begin
      slv_bdone <= 1'b0;
      if (bus_if.bstart) begin
        n_bstart <= n_bstart + 1;
        if (!slv_mute) begin
          slv_bdone <= 1'b1;
          slv_rdata <= slv_rd_val;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic do_req(input string tag, input logic we, input tsize_e sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int cyc);
    cyc = start;
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_load(input string tag, input tsize_e sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    int c;
    int nb;
    slv_rd_val = rd;
    nb = n_bstart;
    do_req(tag, 1'b0, sz, uns, a, 32'h0);
    check({tag, "_addr"}, bus_if.addr, a);
    check({tag, "_tsize"}, 32'(bus_if.tsize), 32'(sz));
    wait_resp(1, c);
    check({tag, "_cyc"}, 32'(c), 32'd3);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    @(negedge clk);
    check({tag, "_nbstart"}, 32'(n_bstart - nb), 32'd1);
  endtask

  task automatic run_sub_store(input string tag, input tsize_e sz, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_merge,
                               input logic [31:0] exp_rep);
    int c;
    int nb;
    slv_rd_val = 32'h11223344;
    nb = n_bstart;
    do_req(tag, 1'b1, sz, 1'b0, a, wd);
`ifdef DBUS_MASTER_RMW_EN
    check({tag, "_rd_bstart"}, 32'(bus_if.bstart), 32'd1);
    check({tag, "_rd_ttype"}, 32'(bus_if.ttype), 32'(READ));
    check({tag, "_rd_addr"}, bus_if.addr, {a[31:2], 2'b00});
    check({tag, "_rd_tsize"}, 32'(bus_if.tsize), 32'(WORD));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_wr_bstart"}, 32'(bus_if.bstart), 32'd1);
    check({tag, "_wr_ttype"}, 32'(bus_if.ttype), 32'(WRITE));
    check({tag, "_wr_addr"}, bus_if.addr, {a[31:2], 2'b00});
    check({tag, "_wr_tsize"}, 32'(bus_if.tsize), 32'(WORD));
    check({tag, "_wr_wdata"}, bus_if.wdata, exp_merge);
    wait_resp(3, c);
    check({tag, "_cyc"}, 32'(c), 32'd5);
    @(negedge clk);
    check({tag, "_nbstart"}, 32'(n_bstart - nb), 32'd2);
`else
    check({tag, "_wr_bstart"}, 32'(bus_if.bstart), 32'd1);
    check({tag, "_wr_ttype"}, 32'(bus_if.ttype), 32'(WRITE));
    check({tag, "_wr_addr"}, bus_if.addr, a);
    check({tag, "_wr_tsize"}, 32'(bus_if.tsize), 32'(sz));
    check({tag, "_wr_wdata"}, bus_if.wdata, exp_rep);
    check({tag, "_merge_unused"}, 32'(exp_merge != exp_rep), 32'd1);
    wait_resp(1, c);
    check({tag, "_cyc"}, 32'(c), 32'd3);
    @(negedge clk);
    check({tag, "_nbstart"}, 32'(n_bstart - nb), 32'd1);
`endif
  endtask

  task automatic run_misaligned(input string tag, input logic we, input tsize_e sz, input logic [31:0] a);
    int c;
    int nb;
    nb = n_bstart;
    do_req(tag, we, sz, 1'b0, a, 32'hFFFF_FFFF);
    check({tag, "_bstart"}, 32'(bus_if.bstart), 32'd0);
    wait_resp(1, c);
    check({tag, "_cyc"}, 32'(c), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd1);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
    @(negedge clk);
    check({tag, "_nbstart"}, 32'(n_bstart - nb), 32'd0);
  endtask

  initial begin
    int c;
    int nb;
    checks       = 0;
    errors       = 0;
    n_bstart     = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = WORD;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    inj_bdone    = 1'b0;
    slv_mute     = 1'b0;
    slv_rd_val   = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_bstart", 32'(bus_if.bstart), 32'd0);
    check("rst_addr", bus_if.addr, 32'h0);
    check("rst_wdata", bus_if.wdata, 32'h0);
    check("rst_ttype", 32'(bus_if.ttype), 32'(READ));
    check("rst_tsize", 32'(bus_if.tsize), 32'(WORD));
    rst_n = 1'b1;
    @(negedge clk);

    // LW with per-cycle bus checks
    slv_rd_val = 32'hDEADBEEF;
    nb = n_bstart;
    do_req("lw", 1'b0, WORD, 1'b0, 32'h100, 32'h0);
    check("lw_bstart", 32'(bus_if.bstart), 32'd1);
    check("lw_addr", bus_if.addr, 32'h100);
    check("lw_ttype", 32'(bus_if.ttype), 32'(READ));
    check("lw_tsize", 32'(bus_if.tsize), 32'(WORD));
    check("lw_ready_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("lw_c2_bstart", 32'(bus_if.bstart), 32'd0);
    check("lw_c2_addr", bus_if.addr, 32'h100);
    check("lw_c2_valid", 32'(resp_valid), 32'd0);
    wait_resp(2, c);
    check("lw_cyc", 32'(c), 32'd3);
    check("lw_rdata", resp_rdata, 32'hDEADBEEF);
    check("lw_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    check("lw_pulse", 32'(resp_valid), 32'd0);
    check("lw_nbstart", 32'(n_bstart - nb), 32'd1);

    run_load("lb", BYTE, 1'b0, 32'h103, 32'h0000_0080, 32'hFFFF_FF80);
    run_load("lbu", BYTE, 1'b1, 32'h103, 32'h0000_0080, 32'h0000_0080);
    run_load("lb_pos", BYTE, 1'b0, 32'h101, 32'h0000_007F, 32'h0000_007F);
    run_load("lh", HALFWORD, 1'b0, 32'h102, 32'h0000_8001, 32'hFFFF_8001);
    run_load("lhu", HALFWORD, 1'b1, 32'h102, 32'h0000_8001, 32'h0000_8001);

    // Full-word store
    slv_rd_val = 32'hFFFF_FFFF;
    do_req("sw", 1'b1, WORD, 1'b0, 32'h200, 32'h1234_5678);
    check("sw_ttype", 32'(bus_if.ttype), 32'(WRITE));
    check("sw_wdata", bus_if.wdata, 32'h1234_5678);
    check("sw_addr", bus_if.addr, 32'h200);
    wait_resp(1, c);
    check("sw_cyc", 32'(c), 32'd3);
    check("sw_rdata", resp_rdata, 32'h0);
    check("sw_err", 32'(resp_err), 32'd0);
    @(negedge clk);

    run_sub_store("sb", BYTE, 32'h102, 32'hCDEF_12AB, 32'h11AB_3344, 32'hABAB_ABAB);
    run_sub_store("sb0", BYTE, 32'h100, 32'h0000_0055, 32'h1122_3355, 32'h5555_5555);
    run_sub_store("sh", HALFWORD, 32'h102, 32'h1234_BEEF, 32'hBEEF_3344, 32'hBEEF_BEEF);

    run_misaligned("mis_lw", 1'b0, WORD, 32'h102);
    run_misaligned("mis_sh", 1'b1, HALFWORD, 32'h101);

    // Timeout: issue cycle 1, eight wait cycles, response in cycle 10
    slv_mute = 1'b1;
    do_req("to", 1'b0, WORD, 1'b0, 32'h300, 32'h0);
    wait_resp(1, c);
    check("to_cyc", 32'(c), 32'd10);
    check("to_err", 32'(resp_err), 32'd1);
    check("to_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    slv_mute = 1'b0;
    run_load("after_to", WORD, 1'b0, 32'h104, 32'h55AA_55AA, 32'h55AA_55AA);

    // Reset while waiting, then a stale bdone
    slv_mute = 1'b1;
    do_req("rst_mid", 1'b0, WORD, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bstart", 32'(bus_if.bstart), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_addr", bus_if.addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj_bdone = 1'b1;
    @(negedge clk);
    inj_bdone = 1'b0;
    check("stale_valid", 32'(resp_valid), 32'd0);
    check("stale_ready", 32'(req_ready), 32'd1);
    check("stale_bstart", 32'(bus_if.bstart), 32'd0);
    @(negedge clk);
    check("stale_valid2", 32'(resp_valid), 32'd0);
    slv_mute = 1'b0;
    run_load("after_rst", WORD, 1'b0, 32'h108, 32'h0102_0304, 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dbus_master.md
# dbus_master

Data-side bus initiator between the CPU load/store stage and the shared slave bus. It turns one CPU memory request into one or two bus transactions using the bstart/bdone handshake. On loads it sign- or zero-extends the returned data. On sub-word stores it performs a read-modify-write, because slaves write whole words. It reports misalignment and unanswered transactions back to the CPU as errors.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for bdone before the transaction is aborted. A value of 0 disables the timeout.

Ports:
- clk  input  1  single clock for the block
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  CPU request valid
- req_ready  output  1  block can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  access size, bus_pkg::tsize_e (BYTE, HALFWORD, WORD)
- req_unsigned  input  1  load zero-extends when set, sign-extends when clear
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse; response fields valid
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access or timeout
- bus  master_bus_if.master  —  drives bstart, ttype, tsize, addr[31:0], wdata[31:0]; samples bdone and rdata[31:0]. ss is decoded by the interconnect.

## Operation
- States: IDLE, ISSUE, WAIT, RMW_ISSUE_RD, RMW_WAIT_RD, RESP.
- IDLE: the request is captured when req_valid && req_ready.
  - Misaligned requests go straight to RESP with err=1 and start no bus cycle. Misaligned means WORD with addr[1:0]≠0, or HALFWORD with addr[0]≠0.
  - Sub-word stores go to RMW_ISSUE_RD.
  - All other requests go to ISSUE.
- ISSUE / RMW_ISSUE_RD: bstart=1 for exactly one cycle.
  - RMW_ISSUE_RD issues a WORD READ at {addr[31:2],2'b00}.
- WAIT / RMW_WAIT_RD: bstart=0 and the timeout counter runs. bdone is also honoured in the issue cycle.
  - On bdone, RMW_WAIT_RD merges the request lanes into the returned word and goes to ISSUE. ISSUE then issues a WORD WRITE of the merged word at the aligned address.
  - On bdone, WAIT goes to RESP.
  - On timeout, either wait state goes to RESP with err=1.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Load extension:
  - Slaves return the selected lane zero-extended in rdata[7:0] or rdata[15:0].
  - The block sign-extends from bit 7 (BYTE) or bit 15 (HALFWORD) unless req_unsigned is set.
  - WORD data passes through unchanged.
- Merge: byte lane addr[1:0] or halfword lane addr[1] of the read word is replaced by req_wdata[7:0] or req_wdata[15:0].
- addr, tsize, ttype and wdata are held stable from the bstart cycle through the bdone cycle.
- bdone seen in IDLE or RESP is ignored; it is a stale or spurious response.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bstart=0, addr=0, wdata=0, ttype=READ, tsize=WORD. State is IDLE.
- Load or full-word store against a one-cycle slave:
  - request accepted at edge 0;
  - bstart in cycle 1;
  - bdone in cycle 2;
  - resp_valid in cycle 3.
- Sub-word store with RMW: read bstart in cycle 1, bdone in cycle 2, write bstart in cycle 3, bdone in cycle 4, resp_valid in cycle 5.
- Misaligned request: resp_valid in cycle 1 with err=1.
- Timeout: the counter resets at every issue. An abort happens when the counter reaches TIMEOUT_CYCLES in a wait state without bdone.
- Reset mid-operation: immediate return to IDLE with bstart low and no response. The first request after reset is accepted normally.
- Back-to-back requests: req_ready rises in the cycle after RESP. Minimum spacing between requests is 4 cycles.

## Configuration
- DBUS_MASTER_RMW_EN defined: sub-word stores use the read-modify-write sequence described above.
- DBUS_MASTER_RMW_EN undefined: sub-word stores go directly to ISSUE.
  - tsize is BYTE or HALFWORD.
  - wdata is the store data replicated across all lanes.
  - Latency is the same as a word store.
  - The RMW states and merge logic are not compiled.

## Structure
- bus_pkg holds tsize_e, ttype_e and the new dbus_master_state_e.
- Sub-module dbus_lane_unit is purely combinational. It does load lane extension, store lane merge and misalignment detection.
- The FSM, timeout counter and request registers stay in dbus_master.

## Test plan
- LW at 0x100, slave returns 0xDEADBEEF → one bus READ (tsize WORD, addr 0x100); resp_rdata=0xDEADBEEF, err=0, resp_valid in cycle 3.
- LB at 0x103, slave rdata=0x00000080 → resp_rdata=0xFFFFFF80. The same access as LBU → resp_rdata=0x00000080.
- SB 0xAB at 0x102 over memory word 0x11223344, RMW enabled → READ at 0x100, then WRITE 0x11AB3344 at 0x100; resp in cycle 5.
- LW at 0x102 or SH at 0x101 → no bstart; resp_valid in cycle 1 with err=1 and rdata=0.
- Slave never asserts bdone, TIMEOUT_CYCLES=8 → resp_err=1 after 8 wait cycles, then the next request completes normally.
- rst_n asserted during WAIT, followed by a stale bdone after release → block in IDLE, no resp_valid, bdone ignored.
